// File: rtl/ibex_rvfi_trace_buffer.sv
// Triggered capture buffer for the RVFI retirement stream.
// Arm/trigger/stop control feeds a registered FIFO drained over valid/ready.
//
// state   | meaning
// IDLE    | no capture, waiting for arm_i
// ARMED   | waiting for a retirement that matches the trigger
// CAPTURE | every retirement is pushed into the FIFO
// FROZEN  | capture ended, FIFO can still be drained; only clear_i leaves
module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth        = 16,
  parameter int unsigned DropCntWidth = 16,
  parameter bit          StopOnTrap   = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rvfi_valid,
  input  logic [63:0]                rvfi_order,
  input  logic [31:0]                rvfi_insn,
  input  logic                       rvfi_trap,
  input  logic                       rvfi_intr,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic                       arm_i,
  input  logic                       trig_any_i,
  input  logic [31:0]                trig_pc_i,
  input  logic                       stop_i,
  input  logic                       clear_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_order_o,
  output logic [31:0]                out_pc_o,
  output logic [31:0]                out_insn_o,
  output logic [4:0]                 out_rd_addr_o,
  output logic [31:0]                out_rd_wdata_o,
  output logic                       out_trap_o,
  output logic                       out_intr_o,
  output logic [1:0]                 state_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic                       overflow_o,
  output logic [DropCntWidth-1:0]    drop_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
  } rec_t;

  state_e state_q, state_d;
  logic   capture;
  logic   trig_hit;
  logic   full, empty, push, pop, drop;
  logic   [PW-1:0] wr_ptr, rd_ptr;
  logic   [DropCntWidth-1:0] drop_cnt_q;
  logic   overflow_q;
  rec_t   mem [Depth];
  rec_t   wr_rec, head;
  logic   unused_order_hi;

  // Upper order bits are intentionally not stored.
  assign unused_order_hi = ^rvfi_order[63:32];

  assign trig_hit = trig_any_i | (rvfi_pc_rdata == trig_pc_i);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop      = ~empty & out_ready_i & ~clear_i;
  assign push     = capture & (~full | pop);
  assign drop     = capture & full & ~pop;

  assign wr_rec = '{order:    rvfi_order[31:0],
                    pc:       rvfi_pc_rdata,
                    insn:     rvfi_insn,
                    rd_addr:  rvfi_rd_addr,
                    rd_wdata: rvfi_rd_wdata,
                    trap:     rvfi_trap,
                    intr:     rvfi_intr};

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and capture decision; clear > stop > arm > trigger/trap.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
    end else if (stop_i) begin
      if (state_q == ARMED || state_q == CAPTURE) state_d = FROZEN;
    end else begin
      unique case (state_q)
        IDLE:    if (arm_i) state_d = ARMED;
        ARMED: begin
          if (rvfi_valid && trig_hit) begin
            capture = 1'b1;
            state_d = (StopOnTrap && rvfi_trap) ? FROZEN : CAPTURE;
          end
        end
        CAPTURE: begin
          if (rvfi_valid) begin
            capture = 1'b1;
            if (StopOnTrap && rvfi_trap) state_d = FROZEN;
          end
        end
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO pointers; clear flushes by resetting both.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Record storage, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_rec;
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != {DropCntWidth{1'b1}}) drop_cnt_q <= drop_cnt_q + DropCntWidth'(1);
    end
  end

  // Head record, forced to zero while the FIFO is empty.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr[AW-1:0]];
  end

  assign out_valid_o    = ~empty;
  assign out_order_o    = head.order;
  assign out_pc_o       = head.pc;
  assign out_insn_o     = head.insn;
  assign out_rd_addr_o  = head.rd_addr;
  assign out_rd_wdata_o = head.rd_wdata;
  assign out_trap_o     = head.trap;
  assign out_intr_o     = head.intr;
  assign state_o        = state_q;
  assign level_o        = wr_ptr - rd_ptr;
  assign overflow_o     = overflow_q;
  assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
Name: ibex_rvfi_trace_buffer

Overview:
- Consumes the per-retirement RVFI record stream produced by the tracing core top.
- Captures a triggered window of retired instructions into an on-chip FIFO, under a small arm/trigger/stop state machine.
- Exposes the captured records through a valid/ready drain port for a debug or DMA reader.
- Used in FPGA and silicon bring-up where the simulation tracer is unavailable.

Parameters:
Depth, 16, FIFO entries; power of two, >= 2
DropCntWidth, 16, width of the saturating dropped-record counter
StopOnTrap, 1'b1, when 1 a captured record with trap=1 ends capture (enter FROZEN)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
rvfi_valid  in  1  a retirement record is present this cycle
rvfi_order  in  64  retirement order; low 32 bits stored
rvfi_insn  in  32  instruction word
rvfi_trap  in  1  instruction trapped
rvfi_intr  in  1  first instruction of a trap handler
rvfi_pc_rdata  in  32  PC of the retired instruction
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  destination write data
arm_i  in  1  pulse: IDLE -> ARMED
trig_any_i  in  1  1: trigger on any retirement; 0: trigger on PC match
trig_pc_i  in  32  trigger PC
stop_i  in  1  pulse: end capture
clear_i  in  1  pulse: flush FIFO and counters, return to IDLE
out_valid_o  out  1  head record available
out_ready_i  in  1  reader accepts the head record
out_order_o  out  32  head record order (low 32 bits)
out_pc_o  out  32  head record PC
out_insn_o  out  32  head record instruction
out_rd_addr_o  out  5  head record rd
out_rd_wdata_o  out  32  head record rd data
out_trap_o  out  1  head record trap
out_intr_o  out  1  head record intr
state_o  out  2  0=IDLE 1=ARMED 2=CAPTURE 3=FROZEN
level_o  out  $clog2(Depth)+1  FIFO occupancy
overflow_o  out  1  sticky; at least one record was dropped
drop_cnt_o  out  DropCntWidth  dropped records, saturating at all-ones

Behaviour:
- Reset (rst_i=1 at a clock edge) state:
  - state IDLE, FIFO empty, level_o=0, out_valid_o=0.
  - overflow_o=0, drop_cnt_o=0.
  - All out_* data outputs = 0.
  - Reset mid-capture discards all stored records.
- Control priority within a cycle: clear_i > stop_i > arm_i > trigger/trap events.
- State machine:
  - IDLE: no capture. arm_i -> ARMED.
  - ARMED: a record triggers when rvfi_valid=1 and (trig_any_i=1 or rvfi_pc_rdata==trig_pc_i). The triggering record is captured and state -> CAPTURE. arm_i while ARMED has no effect.
  - CAPTURE: every rvfi_valid=1 cycle pushes one record. stop_i -> FROZEN; a record arriving in the same cycle as stop_i is not captured. If StopOnTrap=1 and a captured record has rvfi_trap=1, that record is stored, then -> FROZEN.
  - FROZEN: no capture; draining continues. arm_i is ignored; only clear_i leaves FROZEN.
  - clear_i from any state: -> IDLE, FIFO flushed, overflow_o and drop_cnt_o cleared. Any record arriving that cycle is discarded; any pop that cycle is ignored.
- FIFO:
  - Registered storage with read/write pointers of $clog2(Depth)+1 bits; wrap at Depth.
  - Full when the pointers differ only in the MSB; empty when equal.
  - A push becomes visible on out_valid_o one cycle after the rvfi_valid cycle; no combinational path from rvfi_* to out_*.
  - out_* fields show the head entry whenever out_valid_o=1 and stay stable until the pop.
  - Pop occurs when out_valid_o & out_ready_i.
  - Full with simultaneous push and pop: both occur, nothing is dropped, level stays at Depth.
  - Full, push, no pop: the record is dropped, overflow_o set, drop_cnt_o incremented (saturating); the FIFO is unchanged. Capture continues; the state is unaffected.
  - Empty with push and pop requested in the same cycle: no pop, because out_valid_o=0.
  - level_o = push - pop occupancy, updated the cycle after each event.
- The trigger PC compare is full 32-bit equality; order is truncated to bits [31:0].

Test Plan:
- Reset, then arm_i, trig_any_i=0, trig_pc_i=0x100; retire PCs 0x0F8, 0xFC, 0x100, 0x104 with out_ready_i=0 -> state goes ARMED then CAPTURE; level_o=2; head out_pc_o=0x100, then 0x104 after one pop.
- Fill with Depth=16 records, out_ready_i=0, then retire 3 more -> level_o=16, overflow_o=1, drop_cnt_o=3; the drained PCs are the first 16 in order.
- While full, assert out_ready_i=1 with continuous retirements -> no drops; drop_cnt_o is unchanged and level_o stays 16.
- In CAPTURE with StopOnTrap=1, retire a record with trap=1 at PC 0x200, then 0x300 with intr=1 -> state FROZEN; the last stored record has PC 0x200 and trap=1; 0x300 is not stored.
- stop_i in the same cycle as a retirement at 0x400 -> FROZEN; 0x400 is not stored. Then clear_i together with out_ready_i=1 -> IDLE, level_o=0, overflow_o=0, drop_cnt_o=0.
- Assert rst_i mid-capture with 5 records stored -> the next cycle shows state_o=0, level_o=0, out_valid_o=0; the next arm/trigger cycle captures normally.
